// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkg
// Brief    : Shared types and helpers for ndata stream blocks (mux modes,
//            packet-mux FSM states, round-robin index search).
// Revision : 1.0 - initial release
// ============================================================================
package stream_pkg;

    typedef enum logic [0:0] {
        MUX_EXTERNAL    = 1'b0,
        MUX_ROUND_ROBIN = 1'b1
    } mux_mode_t;

    typedef enum logic [0:0] {
        MUX_ST_IDLE   = 1'b0,
        MUX_ST_LOCKED = 1'b1
    } mux_state_t;

    // Widest request vector the round-robin helper can search.
    localparam int unsigned c_RR_MAX_REQ = 32;

    // First set request strictly after ptr, wrapping at n (n <= c_RR_MAX_REQ).
    // Returns ptr when no request is set; callers gate on |req.
    function automatic logic [31:0] rr_next_idx(
        input logic [c_RR_MAX_REQ-1:0] req,
        input logic [31:0]             ptr,
        input logic [31:0]             n
    );
        logic [31:0]             idx;
        logic [c_RR_MAX_REQ-1:0] shifted;
        logic                    found;
        rr_next_idx = ptr;
        found       = 1'b0;
        for (int unsigned k = 1; k <= c_RR_MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            shifted = req >> idx;
            if (!found && (k <= n) && shifted[0]) begin
                rr_next_idx = idx;
                found       = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ndata_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ndata_skid_buffer
// Brief    : Two-entry ready/valid register slice for ndata beats with a
//            generic sideband. Upstream ready comes straight from a flop.
// Revision : 1.0 - initial release
// ============================================================================
module ndata_skid_buffer #(
    parameter type data_t       = logic [31:0],
    parameter int  NUM_ELEMENTS = 4,
    parameter int  SIDE_W       = 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         i_valid,
    output logic                                         o_ready,
    input  logic [NUM_ELEMENTS-1:0][$bits(data_t)-1:0]   i_data,
    input  logic [NUM_ELEMENTS-1:0]                      i_keep,
    input  logic [SIDE_W-1:0]                            i_side,
    output logic                                         o_valid,
    input  logic                                         i_ready,
    output logic [NUM_ELEMENTS-1:0][$bits(data_t)-1:0]   o_data,
    output logic [NUM_ELEMENTS-1:0]                      o_keep,
    output logic [SIDE_W-1:0]                            o_side
);

    localparam int c_EW = NUM_ELEMENTS * $bits(data_t) + NUM_ELEMENTS + SIDE_W;

    logic [c_EW-1:0] r_mem [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            r_ready;

    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count_nxt;
    logic [c_EW-1:0] w_in_entry;
    logic [c_EW-1:0] w_out_entry;

    assign w_in_entry  = {i_data, i_keep, i_side};
    assign w_out_entry = r_mem[r_rd_ptr];
    assign {o_data, o_keep, o_side} = w_out_entry;

    assign o_valid = (r_count != 2'd0);
    assign o_ready = r_ready;

    assign w_push      = i_valid && r_ready;
    assign w_pop       = o_valid && i_ready;
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

    // Occupancy, pointers and storage; ready is precomputed from next occupancy
    // so it only drops when both entries will be held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ndata_packet_mux.sv
`default_nettype none
// ============================================================================
// Module   : ndata_packet_mux
// Brief    : Packet-granular N:1 ndata multiplexer. The grant comes from an
//            external select handshake or round-robin arbitration and is held
//            until the last beat of the packet. Optional skid-buffered output.
// Revision : 1.0 - initial release
// ============================================================================
module ndata_packet_mux
    import stream_pkg::*;
#(
    parameter type       data_t       = logic [31:0],
    parameter int        NUM_ELEMENTS = 4,
    parameter int        NUM_STREAMS  = 4,
    parameter mux_mode_t MODE         = MUX_EXTERNAL,
    parameter bit        OUT_REG      = 1'b1,
    parameter int        IDX_W        = $clog2(NUM_STREAMS)
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    // stream select (external mode only)
    input  logic                                                    i_select_valid,
    output logic                                                    o_select_ready,
    input  logic [IDX_W-1:0]                                        i_select_data,
    // input streams
    input  logic [NUM_STREAMS-1:0]                                  i_in_valid,
    output logic [NUM_STREAMS-1:0]                                  o_in_ready,
    input  logic [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0][$bits(data_t)-1:0] i_in_data,
    input  logic [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0]                i_in_keep,
    input  logic [NUM_STREAMS-1:0]                                  i_in_last,
    // merged output stream
    output logic                                                    o_out_valid,
    input  logic                                                    i_out_ready,
    output logic [NUM_ELEMENTS-1:0][$bits(data_t)-1:0]              o_out_data,
    output logic [NUM_ELEMENTS-1:0]                                 o_out_keep,
    output logic                                                    o_out_last,
    output logic [IDX_W-1:0]                                        o_out_id,
    output logic                                                    o_sel_err
);

    localparam logic [31:0] c_NUM_STREAMS = NUM_STREAMS;

    mux_state_t                                  r_state;
    mux_state_t                                  w_state_nxt;
    logic [IDX_W-1:0]                            r_grant;
    logic [IDX_W-1:0]                            w_grant_nxt;
    logic [IDX_W-1:0]                            r_ptr;
    logic [IDX_W-1:0]                            w_ptr_nxt;
    logic                                        r_sel_err;
    logic                                        w_sel_err_nxt;
    logic [IDX_W-1:0]                            w_rr_idx;

    logic                                        w_g_valid;
    logic [NUM_ELEMENTS-1:0][$bits(data_t)-1:0]  w_g_data;
    logic [NUM_ELEMENTS-1:0]                     w_g_keep;
    logic                                        w_g_last;
    logic                                        w_lock_valid;
    logic                                        w_dn_ready;
    logic                                        w_beat_xfer;

    assign o_sel_err    = r_sel_err;
    assign w_lock_valid = (r_state == MUX_ST_LOCKED) && w_g_valid;
    assign w_beat_xfer  = w_lock_valid && w_dn_ready;

    // Steer the currently granted input onto the internal beat signals.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_data  = '0;
        w_g_keep  = '0;
        w_g_last  = 1'b0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_g_valid = i_in_valid[i];
                w_g_data  = i_in_data[i];
                w_g_keep  = i_in_keep[i];
                w_g_last  = i_in_last[i];
            end
        end
    end

    // Next round-robin candidate: first valid input after the last winner.
    always_comb begin
        w_rr_idx = IDX_W'(rr_next_idx(c_RR_MAX_REQ'(i_in_valid), 32'(r_ptr), c_NUM_STREAMS));
    end

    // Grant FSM: pick a stream in IDLE, forward its beats while LOCKED.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_ptr_nxt      = r_ptr;
        w_sel_err_nxt  = 1'b0;
        o_select_ready = 1'b0;
        o_in_ready     = '0;
        case (r_state)
            MUX_ST_IDLE: begin
                if (MODE == MUX_EXTERNAL) begin
                    // Held low while reset is applied so nothing is consumed.
                    o_select_ready = rst_n;
                    if (i_select_valid) begin
                        if (32'(i_select_data) < c_NUM_STREAMS) begin
                            w_grant_nxt = i_select_data;
                            w_state_nxt = MUX_ST_LOCKED;
                        end else begin
                            w_sel_err_nxt = 1'b1;
                        end
                    end
                end else begin
                    if (|i_in_valid) begin
                        w_grant_nxt = w_rr_idx;
                        w_ptr_nxt   = w_rr_idx;
                        w_state_nxt = MUX_ST_LOCKED;
                    end
                end
            end
            MUX_ST_LOCKED: begin
                for (int i = 0; i < NUM_STREAMS; i++) begin
                    o_in_ready[i] = (r_grant == IDX_W'(i)) && w_dn_ready;
                end
                if (w_beat_xfer && w_g_last) begin
                    w_state_nxt = MUX_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = MUX_ST_IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and error pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= MUX_ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= IDX_W'(NUM_STREAMS - 1);
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sel_err <= w_sel_err_nxt;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic             w_skid_ready;
            logic [IDX_W:0]   w_side_out;

            ndata_skid_buffer #(
                .data_t       (data_t),
                .NUM_ELEMENTS (NUM_ELEMENTS),
                .SIDE_W       (IDX_W + 1)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_valid (w_lock_valid),
                .o_ready (w_skid_ready),
                .i_data  (w_g_data),
                .i_keep  (w_g_keep),
                .i_side  ({w_g_last, r_grant}),
                .o_valid (o_out_valid),
                .i_ready (i_out_ready),
                .o_data  (o_out_data),
                .o_keep  (o_out_keep),
                .o_side  (w_side_out)
            );

            assign w_dn_ready = w_skid_ready;
            assign o_out_last = w_side_out[IDX_W];
            assign o_out_id   = w_side_out[IDX_W-1:0];
        end else begin : g_out_comb
            assign w_dn_ready  = i_out_ready;
            assign o_out_valid = w_lock_valid;
            assign o_out_data  = w_g_data;
            assign o_out_keep  = w_g_keep;
            assign o_out_last  = w_g_last;
            assign o_out_id    = r_grant;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ndata_packet_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ndata_packet_mux
// Brief    : Self-checking bench for ndata_packet_mux: one external-select
//            instance with combinational output, one round-robin instance
//            with the skid-buffered output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ndata_packet_mux;
    import stream_pkg::*;

    localparam int c_NS = 4;
    localparam int c_NE = 4;

    typedef struct packed {
        logic [c_NE-1:0][31:0] data;
        logic [c_NE-1:0]       keep;
        logic                  last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // external-select instance
    logic                        ext_sel_valid, ext_sel_ready;
    logic [2:0]                  ext_sel_data;
    logic [c_NS-1:0]             ext_in_valid, ext_in_ready, ext_in_last;
    logic [c_NS-1:0][c_NE-1:0][31:0] ext_in_data;
    logic [c_NS-1:0][c_NE-1:0]   ext_in_keep;
    logic                        ext_out_valid, ext_out_ready, ext_out_last, ext_sel_err;
    logic [c_NE-1:0][31:0]       ext_out_data;
    logic [c_NE-1:0]             ext_out_keep;
    logic [2:0]                  ext_out_id;

    // round-robin instance
    logic                        rr_sel_valid, rr_sel_ready;
    logic [1:0]                  rr_sel_data;
    logic [c_NS-1:0]             rr_in_valid, rr_in_ready, rr_in_last;
    logic [c_NS-1:0][c_NE-1:0][31:0] rr_in_data;
    logic [c_NS-1:0][c_NE-1:0]   rr_in_keep;
    logic                        rr_out_valid, rr_out_ready, rr_out_last, rr_sel_err;
    logic [c_NE-1:0][31:0]       rr_out_data;
    logic [c_NE-1:0]             rr_out_keep;
    logic [1:0]                  rr_out_id;

    ndata_packet_mux #(
        .data_t(logic [31:0]), .NUM_ELEMENTS(c_NE), .NUM_STREAMS(c_NS),
        .MODE(MUX_EXTERNAL), .OUT_REG(1'b0), .IDX_W(3)
    ) u_ext (
        .clk(clk), .rst_n(rst_n),
        .i_select_valid(ext_sel_valid), .o_select_ready(ext_sel_ready), .i_select_data(ext_sel_data),
        .i_in_valid(ext_in_valid), .o_in_ready(ext_in_ready), .i_in_data(ext_in_data),
        .i_in_keep(ext_in_keep), .i_in_last(ext_in_last),
        .o_out_valid(ext_out_valid), .i_out_ready(ext_out_ready), .o_out_data(ext_out_data),
        .o_out_keep(ext_out_keep), .o_out_last(ext_out_last), .o_out_id(ext_out_id),
        .o_sel_err(ext_sel_err)
    );

    ndata_packet_mux #(
        .data_t(logic [31:0]), .NUM_ELEMENTS(c_NE), .NUM_STREAMS(c_NS),
        .MODE(MUX_ROUND_ROBIN), .OUT_REG(1'b1), .IDX_W(2)
    ) u_rr (
        .clk(clk), .rst_n(rst_n),
        .i_select_valid(rr_sel_valid), .o_select_ready(rr_sel_ready), .i_select_data(rr_sel_data),
        .i_in_valid(rr_in_valid), .o_in_ready(rr_in_ready), .i_in_data(rr_in_data),
        .i_in_keep(rr_in_keep), .i_in_last(rr_in_last),
        .o_out_valid(rr_out_valid), .i_out_ready(rr_out_ready), .o_out_data(rr_out_data),
        .o_out_keep(rr_out_keep), .o_out_last(rr_out_last), .o_out_id(rr_out_id),
        .o_sel_err(rr_sel_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ext_sel_valid = 1'b0; ext_sel_data = '0;
        ext_in_valid = '0; ext_in_last = '0; ext_in_data = '0; ext_in_keep = '1;
        ext_out_ready = 1'b1;
        rr_sel_valid = 1'b0; rr_sel_data = '0;
        rr_in_valid = '0; rr_in_last = '0; rr_in_data = '0; rr_in_keep = '1;
        rr_out_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Beat k of the directed stream-2 packet (3 beats, last on k == 2).
    function automatic beat_t ext_beat(input int k);
        beat_t b;
        for (int e = 0; e < c_NE; e++) b.data[e] = 32'h2000 + 32'(16 * k + e);
        b.keep = 4'(k + 5);
        b.last = (k == 2);
        return b;
    endfunction

    beat_t            src_q [c_NS][$];
    beat_t            exp_q [c_NS][$];
    logic [c_NS-1:0]  src_vld;
    int               gen_beats, got_beats, n_seen, n_in;
    int               seen_id [8];
    int               seen_cyc[8];
    logic             seen_last[8];
    logic             in_pkt, prev_stall, found, sel_taken, done;
    logic [1:0]       cur_id;
    logic [159:0]     prev_payload;
    logic [c_NS-1:0]  in_hs;
    logic             out_hs, sel_hs;
    int               beat;
    beat_t            exp_b, drv_b;

    initial begin
        // ---------------- reset state ----------------
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check_eq("rst_ext_out_valid", ext_out_valid, 0);
        check_eq("rst_ext_sel_ready", ext_sel_ready, 0);
        check_eq("rst_ext_in_ready", ext_in_ready, 0);
        check_eq("rst_ext_sel_err", ext_sel_err, 0);
        check_eq("rst_ext_out_id", ext_out_id, 0);
        check_eq("rst_rr_out_valid", rr_out_valid, 0);
        check_eq("rst_rr_in_ready", rr_in_ready, 0);
        check_eq("rst_rr_out_id", rr_out_id, 0);
        step();
        rst_n = 1'b1;

        // ---------------- external select = 2, 3-beat packet ----------------
        ext_in_valid = 4'b0111;
        drv_b = ext_beat(0);
        ext_in_data[2] = drv_b.data; ext_in_keep[2] = drv_b.keep; ext_in_last[2] = drv_b.last;
        ext_sel_data = 3'd2; ext_sel_valid = 1'b1;
        beat = 0; sel_taken = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            check_eq("ext_in0_ready", ext_in_ready[0], 0);
            check_eq("ext_in1_ready", ext_in_ready[1], 0);
            if (sel_taken && beat < 3) check_eq("ext_sel_ready_locked", ext_sel_ready, 0);
            if (beat == 3) begin
                check_eq("ext_sel_ready_after", ext_sel_ready, 1);
                check_eq("ext_out_valid_after", ext_out_valid, 0);
                done = 1'b1;
            end
            sel_hs = ext_sel_valid && ext_sel_ready;
            out_hs = ext_out_valid && ext_out_ready;
            if (out_hs) begin
                exp_b = ext_beat(beat);
                check_eq("ext_beat", {ext_out_data, ext_out_keep, ext_out_last}, exp_b);
                check_eq("ext_out_id", ext_out_id, 2);
            end
            step();
            if (sel_hs) begin
                sel_taken = 1'b1;
                ext_sel_valid = 1'b0;
            end
            if (out_hs) begin
                beat++;
                if (beat == 3) begin
                    ext_in_valid[2] = 1'b0;
                end else begin
                    drv_b = ext_beat(beat);
                    ext_in_data[2] = drv_b.data; ext_in_keep[2] = drv_b.keep; ext_in_last[2] = drv_b.last;
                end
            end
        end
        check_eq("ext_pkt_done", done, 1);

        // ---------------- external select out of range ----------------
        ext_sel_data = 3'd5; ext_sel_valid = 1'b1;
        @(negedge clk);
        check_eq("bad_sel_ready", ext_sel_ready, 1);
        check_eq("bad_sel_err_before", ext_sel_err, 0);
        step();
        ext_sel_valid = 1'b0;
        @(negedge clk);
        check_eq("bad_sel_err_pulse", ext_sel_err, 1);
        check_eq("bad_sel_in_ready", ext_in_ready, 0);
        check_eq("bad_sel_out_valid", ext_out_valid, 0);
        check_eq("bad_sel_still_idle", ext_sel_ready, 1);
        step();
        @(negedge clk);
        check_eq("bad_sel_err_clear", ext_sel_err, 0);
        check_eq("bad_sel_in_ready2", ext_in_ready, 0);

        // ---------------- round robin: all valid, 1-beat packets ----------------
        do_reset();
        for (int i = 0; i < c_NS; i++) rr_in_data[i] = {c_NE{32'h100 + 32'(i)}};
        rr_in_last = '1;
        rr_in_valid = '1;
        n_seen = 0;
        for (int cyc = 0; cyc < 60 && n_seen < 6; cyc++) begin
            @(negedge clk);
            if (rr_out_valid && rr_out_ready) begin
                check_eq("rr4_data", rr_out_data, {c_NE{32'h100 + 32'(rr_out_id)}});
                seen_id[n_seen] = int'(rr_out_id);
                seen_cyc[n_seen] = cyc;
                n_seen++;
            end
            step();
        end
        check_eq("rr4_count", n_seen, 6);
        for (int j = 0; j < n_seen; j++) begin
            check_eq($sformatf("rr4_id[%0d]", j), seen_id[j], j % 4);
            if (j > 0) check_eq($sformatf("rr4_gap[%0d]", j), seen_cyc[j] - seen_cyc[j-1], 2);
        end

        // ---------------- round robin: streams 1 and 3, 2-beat packets ----------------
        do_reset();
        rr_in_valid = 4'b1010;
        rr_in_last = '0;
        n_seen = 0;
        for (int cyc = 0; cyc < 80 && n_seen < 8; cyc++) begin
            @(negedge clk);
            if (rr_out_valid && rr_out_ready) begin
                seen_id[n_seen] = int'(rr_out_id);
                seen_last[n_seen] = rr_out_last;
                seen_cyc[n_seen] = cyc;
                n_seen++;
            end
            in_hs = rr_in_valid & rr_in_ready;
            step();
            for (int i = 0; i < c_NS; i++) if (in_hs[i]) rr_in_last[i] = ~rr_in_last[i];
        end
        check_eq("rr2_count", n_seen, 8);
        for (int j = 0; j < n_seen; j++) begin
            check_eq($sformatf("rr2_id[%0d]", j), seen_id[j], ((j / 2) % 2 == 1) ? 3 : 1);
            check_eq($sformatf("rr2_last[%0d]", j), seen_last[j], j % 2);
            if (j % 2 == 1) check_eq($sformatf("rr2_contig[%0d]", j), seen_cyc[j] - seen_cyc[j-1], 1);
        end

        // ---------------- randomized traffic with random backpressure ----------------
        do_reset();
        gen_beats = 0;
        while (gen_beats < 1000) begin
            int s, len;
            s = $urandom_range(c_NS - 1, 0);
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) begin
                beat_t bt;
                bt.data = {$urandom, $urandom, $urandom, $urandom};
                bt.keep = 4'($urandom);
                bt.last = (b == len - 1);
                src_q[s].push_back(bt);
                exp_q[s].push_back(bt);
                gen_beats++;
            end
        end
        got_beats = 0; in_pkt = 1'b0; cur_id = '0; prev_stall = 1'b0; prev_payload = '0;
        src_vld = '0;
        for (int cyc = 0; cyc < 20000 && got_beats < gen_beats; cyc++) begin
            // refresh sources: valid stays up until its beat is taken
            for (int i = 0; i < c_NS; i++) begin
                if (!src_vld[i] && src_q[i].size() != 0 && $urandom_range(3, 0) != 0) src_vld[i] = 1'b1;
                if (src_q[i].size() != 0) begin
                    rr_in_data[i] = src_q[i][0].data;
                    rr_in_keep[i] = src_q[i][0].keep;
                    rr_in_last[i] = src_q[i][0].last;
                end
            end
            rr_in_valid = src_vld;
            rr_out_ready = 1'($urandom_range(1, 0));
            @(negedge clk);
            if (prev_stall) begin
                check_eq("stall_valid", rr_out_valid, 1);
                check_eq("stall_payload", {rr_out_data, rr_out_keep, rr_out_last, rr_out_id}, prev_payload);
            end
            if (rr_out_valid && rr_out_ready) begin
                if (in_pkt) check_eq("pkt_contig", rr_out_id, cur_id);
                check_eq("beat_expected", exp_q[rr_out_id].size() != 0, 1);
                if (exp_q[rr_out_id].size() != 0) begin
                    exp_b = exp_q[rr_out_id].pop_front();
                    check_eq("rand_beat", {rr_out_data, rr_out_keep, rr_out_last}, exp_b);
                end
                got_beats++;
                in_pkt = !rr_out_last;
                cur_id = rr_out_id;
            end
            prev_stall = rr_out_valid && !rr_out_ready;
            prev_payload = {rr_out_data, rr_out_keep, rr_out_last, rr_out_id};
            in_hs = rr_in_valid & rr_in_ready;
            step();
            for (int i = 0; i < c_NS; i++) begin
                if (in_hs[i]) begin
                    void'(src_q[i].pop_front());
                    src_vld[i] = 1'b0;
                end
            end
        end
        check_eq("rand_beat_count", got_beats, gen_beats);
        for (int i = 0; i < c_NS; i++) check_eq($sformatf("rand_left[%0d]", i), exp_q[i].size(), 0);

        // ---------------- reset mid-packet ----------------
        do_reset();
        rr_in_valid = 4'b0100;
        rr_in_last = '0;
        n_in = 0;
        for (int cyc = 0; cyc < 20 && n_in < 2; cyc++) begin
            @(negedge clk);
            in_hs = rr_in_valid & rr_in_ready;
            step();
            if (in_hs[2]) n_in++;
        end
        check_eq("midrst_beats_in", n_in, 2);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check_eq("midrst_out_valid", rr_out_valid, 0);
        check_eq("midrst_in_ready", rr_in_ready, 0);
        check_eq("midrst_ext_sel_ready", ext_sel_ready, 0);
        check_eq("midrst_ext_in_ready", ext_in_ready, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < c_NS; i++) rr_in_data[i] = {c_NE{32'h300 + 32'(i)}};
        rr_in_last = '1;
        rr_in_valid = '1;
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            if (rr_out_valid && rr_out_ready) begin
                check_eq("midrst_first_id", rr_out_id, 0);
                check_eq("midrst_first_data", rr_out_data, {c_NE{32'h300}});
                found = 1'b1;
            end
            step();
        end
        check_eq("midrst_restart", found, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ndata_packet_mux.md
Name: ndata_packet_mux

Overview:
- Packet-granular N:1 multiplexer for ndata_i streams.
- Supports two modes:
  - EXTERNAL: the stream index comes from a select handshake.
  - ROUND_ROBIN: internal fair arbitration among valid inputs.
- The grant is locked for a whole packet, up to the beat with last set.
- The output is optionally fully registered through a skid buffer, which breaks the out.ready to in.ready combinational path.
- Sits in front of shared consumers (DMA writers, serializers) that merge several producers.

Parameters:
- data_t, logic[31:0], element type.
- NUM_ELEMENTS, 4, elements per beat.
- NUM_STREAMS, 4, input count; must be at least 2.
- MODE, MUX_EXTERNAL, one of MUX_EXTERNAL or MUX_ROUND_ROBIN (stream_pkg::mux_mode_t).
- OUT_REG, 1, 1 = output through a 2-entry skid buffer; 0 = combinational output from the granted input.
- IDX_W, $clog2(NUM_STREAMS), width of stream index.

Ports:
- clk  in  1  clock; the single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- select  ready_valid_i.s  IDX_W data  stream index per packet. Used only when MODE = MUX_EXTERNAL; otherwise ready is tied to 0.
- in[NUM_STREAMS]  ndata_i.s  NUM_ELEMENTS x data_t, keep NUM_ELEMENTS, last 1  input streams.
- out  ndata_i.m  same as in  merged stream.
- out_id  out  IDX_W  index of the stream driving the current out beat; valid when out.valid = 1.
- sel_err  out  1  one-cycle pulse when an out-of-range select is consumed.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - state IDLE, skid buffer empty.
  - out.valid = 0, select.ready = 0, all in[i].ready = 0, sel_err = 0, out_id = 0.
  - RR pointer = NUM_STREAMS-1, so stream 0 has first priority.
  - Reset mid-packet abandons the packet; no partial-packet flush.
- FSM states: IDLE, LOCKED.
- IDLE, MODE = EXTERNAL:
  - select.ready = 1.
  - On a select handshake with data < NUM_STREAMS: grant <= data, go to LOCKED.
  - With data >= NUM_STREAMS: consume the select, pulse sel_err next cycle, stay in IDLE.
- IDLE, MODE = ROUND_ROBIN:
  - If any in[i].valid: grant <= first valid index searching upward from ptr+1 with wrap-around; ptr <= grant; go to LOCKED.
  - No valid input: stay in IDLE.
- LOCKED:
  - in[grant].ready = downstream-ready. That is out.ready when OUT_REG = 0, or "skid not full" when OUT_REG = 1.
  - All other in[i].ready = 0.
  - A beat transfers on in[grant].valid && in[grant].ready. data, keep, last and grant (as out_id) pass unchanged.
  - A transfer with last = 1 returns the FSM to IDLE on the next edge.
- Latency:
  - The grant is registered, so the first beat of a packet can transfer no earlier than the cycle after the select handshake or RR decision.
  - This gives exactly one idle cycle on the input side between packets.
  - OUT_REG = 1 adds one cycle of input-to-output latency and sustains 1 beat/cycle within a packet.
- Skid buffer (OUT_REG = 1):
  - 2 entries.
  - Upstream ready is registered, deasserting only when both entries are full.
  - Never drops or duplicates a beat.
  - out.valid holds with stable payload until out.ready.
- AXI-style rules:
  - out.valid never depends on out.ready.
  - Once asserted, out.valid stays high with stable payload until the handshake.
- keep passes through unmodified; no check for keep = 0 beats.
- A grant to a stream that is not yet valid waits indefinitely. There is no timeout and no re-arbitration while LOCKED.
- Simultaneous events:
  - A select arriving during LOCKED stays pending, since select.ready = 0.
  - A last beat and a new select in the same cycle: the select is taken in the following IDLE cycle.

Decomposition:
- stream_pkg holds:
  - typedef enum mux_mode_t {MUX_EXTERNAL, MUX_ROUND_ROBIN}.
  - A round-robin next-index function, reused by future arbiters.
- One sub-module: ndata_skid_buffer #(data_t, NUM_ELEMENTS, extra IDX_W sideband), instantiated under generate when OUT_REG = 1.

Test Plan:
- EXTERNAL, NUM_STREAMS = 4, OUT_REG = 0:
  - Stimulus: select = 2; in[2] sends 3 beats (last on beat 3); in[0] and in[1] valid continuously.
  - Required: out carries exactly the 3 beats of in[2] with out_id = 2; in[0].ready and in[1].ready stay 0; select.ready = 0 until the cycle after beat 3.
- EXTERNAL, select = 5 with NUM_STREAMS = 4:
  - Required: the select is consumed, sel_err pulses once, FSM stays IDLE, no input ready.
- ROUND_ROBIN, all 4 inputs continuously valid with 1-beat packets:
  - Required: out_id sequence is 0,1,2,3,0,1 with one bubble cycle between packets.
- ROUND_ROBIN, only in[1] and in[3] valid, 2-beat packets:
  - Required: order is 1,3,1,3; each packet is contiguous on out.
- OUT_REG = 1, random out.ready (50%) over 1000 beats:
  - Required: the scoreboard matches in order per packet.
  - Required: out payload is stable while out.valid && !out.ready; no dropped or duplicated beats.
- Reset asserted mid-packet (after beat 2 of 4):
  - Required: next cycle out.valid = 0 and all readies are 0.
  - Required: after release, arbitration restarts with stream 0 priority (RR).
